// File: rtl/contador_ctrl_if.sv
// Bundle of the requester handshakes, the counter-facing signals and job status
// for contador_ctrl. The slave side is the controller; the master side is the client.
interface contador_ctrl_if #(
    parameter int LW = 4
);
    logic          req0_valid;
    logic          req1_valid;
    logic          req0_ready;
    logic          req1_ready;
    logic [1:0]    req0_mode;
    logic [1:0]    req1_mode;
    logic [3:0]    req0_d;
    logic [3:0]    req1_d;
    logic [LW-1:0] req0_len;
    logic [LW-1:0] req1_len;
    logic          req0_stop_rco;
    logic          req1_stop_rco;
    logic          cnt_rco;
    logic [3:0]    cnt_Q;
    logic          enable;
    logic [1:0]    mode;
    logic [3:0]    D;
    logic          busy;
    logic          owner;
    logic          done;
    logic          done_id;
    logic [3:0]    done_q;

    modport master (
        output req0_valid, req1_valid, req0_mode, req1_mode, req0_d, req1_d,
               req0_len, req1_len, req0_stop_rco, req1_stop_rco, cnt_rco, cnt_Q,
        input  req0_ready, req1_ready, enable, mode, D, busy, owner, done,
               done_id, done_q
    );

    modport slave (
        input  req0_valid, req1_valid, req0_mode, req1_mode, req0_d, req1_d,
               req0_len, req1_len, req0_stop_rco, req1_stop_rco, cnt_rco, cnt_Q,
        output req0_ready, req1_ready, enable, mode, D, busy, owner, done,
               done_id, done_q
    );
endinterface

// File: rtl/contador_ctrl.sv
// Job sequencer for the contadorA counter: round-robin grant between two
// requesters, then LOAD -> RUN (len cycles or early rco stop) -> DONE.
module contador_ctrl #(
    parameter int LW = 4
) (
    input logic            clk,
    input logic            reset,
    contador_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    state_t        state_q, state_d;
    logic          ptr_q, ptr_d;
    logic          owner_q, owner_d;
    logic          stop_q, stop_d;
    logic [1:0]    mode_q, mode_d;
    logic [3:0]    d_q, d_d;
    logic [LW-1:0] len_q, len_d;
    logic [LW-1:0] rem_q, rem_d;

    logic          gnt1;
    logic          xfer;
    logic          rco_stop;

    // Requester 1 wins when it is the only one asking, or when both ask and ptr favours it.
    always_comb begin
        gnt1     = bus.req1_valid & (~bus.req0_valid | ptr_q);
        xfer     = (state_q == IDLE) & (bus.req0_valid | bus.req1_valid);
        rco_stop = (state_q == RUN) & stop_q & bus.cnt_rco;
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        stop_d  = stop_q;
        mode_d  = mode_q;
        d_d     = d_q;
        len_d   = len_q;
        rem_d   = rem_q;
        case (state_q)
            IDLE: begin
                if (xfer) begin
                    owner_d = gnt1;
                    mode_d  = gnt1 ? bus.req1_mode     : bus.req0_mode;
                    d_d     = gnt1 ? bus.req1_d        : bus.req0_d;
                    len_d   = gnt1 ? bus.req1_len      : bus.req0_len;
                    stop_d  = gnt1 ? bus.req1_stop_rco : bus.req0_stop_rco;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                rem_d   = len_q;
                state_d = (len_q == '0) ? DONE : RUN;
            end
            RUN: begin
                rem_d = rem_q - LW'(1);
                if (rco_stop || rem_q == LW'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                ptr_d   = ~owner_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= 1'b0;
            owner_q <= 1'b0;
            stop_q  <= 1'b0;
            mode_q  <= '0;
            d_q     <= '0;
            len_q   <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            stop_q  <= stop_d;
            mode_q  <= mode_d;
            d_q     <= d_d;
            len_q   <= len_d;
            rem_q   <= rem_d;
        end
    end

    // Every output is forced low while reset is asserted, even before the first edge.
    always_comb begin
        bus.req0_ready = 1'b0;
        bus.req1_ready = 1'b0;
        bus.enable     = 1'b0;
        bus.mode       = 2'b00;
        bus.D          = 4'b0000;
        bus.busy       = 1'b0;
        bus.owner      = 1'b0;
        bus.done       = 1'b0;
        bus.done_id    = 1'b0;
        bus.done_q     = 4'b0000;
        if (!reset) begin
            bus.req0_ready = xfer & ~gnt1;
            bus.req1_ready = xfer & gnt1;
            bus.busy       = (state_q != IDLE);
            bus.owner      = owner_q;
            case (state_q)
                LOAD: begin
                    bus.enable = 1'b1;
                    bus.mode   = 2'b11;
                    bus.D      = d_q;
                end
                RUN: begin
                    bus.enable = ~rco_stop;
                    bus.mode   = mode_q;
                    bus.D      = d_q;
                end
                DONE: begin
                    bus.done    = 1'b1;
                    bus.done_id = owner_q;
                    bus.done_q  = bus.cnt_Q;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_contador_ctrl.sv
// Randomized and directed checks of contador_ctrl against a job-schedule
// reference model with a scoreboard of expected completions.
module tb_contador_ctrl;
    localparam int LW = 4;

    typedef struct {
        int id;
        int cyc;
    } done_t;

    logic clk = 1'b0;
    logic reset;

    contador_ctrl_if #(.LW(LW)) bus ();

    contador_ctrl #(.LW(LW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int          n_chk = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          rco_cycle = -1;
    int          idle_from = 0;
    bit          ptr_m = 1'b0;
    bit [3:0]    q_drv = 4'd0;
    done_t       sb[$];

    bit          exp_en[int];
    bit [1:0]    exp_mode[int];
    bit [3:0]    exp_D[int];
    bit          exp_owner[int];

    bit          r_valid[2];
    bit [1:0]    r_mode[2];
    bit [3:0]    r_d[2];
    bit [LW-1:0] r_len[2];
    bit          r_stop[2];
    int          r_k[2];

    function automatic void chk(string name, int act, int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endfunction

    task automatic apply();
        bus.req0_valid    = r_valid[0];
        bus.req1_valid    = r_valid[1];
        bus.req0_mode     = r_mode[0];
        bus.req1_mode     = r_mode[1];
        bus.req0_d        = r_d[0];
        bus.req1_d        = r_d[1];
        bus.req0_len      = r_len[0];
        bus.req1_len      = r_len[1];
        bus.req0_stop_rco = r_stop[0];
        bus.req1_stop_rco = r_stop[1];
    endtask

    task automatic set_req(input int i, input bit v, input int md, input int d,
                           input int len, input bit stop, input int k);
        r_valid[i] = v;
        r_mode[i]  = 2'(md);
        r_d[i]     = 4'(d);
        r_len[i]   = LW'(len);
        r_stop[i]  = stop;
        r_k[i]     = k;
    endtask

    task automatic rand_req(input int i);
        int len;
        int k;
        len = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, (1 << LW) - 1));
        k   = int'($urandom_range(0, len + 1));
        if ($urandom_range(0, 2) == 0) k = -1;
        set_req(i, $urandom_range(0, 3) != 0, int'($urandom_range(0, 3)),
                int'($urandom_range(0, 15)), len, 1'($urandom_range(0, 1)), k);
    endtask

    // Job schedule from transfer cycle t: LOAD at t+1, R run cycles, DONE at t+2+R.
    task automatic model(input int id, input int t);
        int  len;
        int  k;
        int  run_cycles;
        bit  stop;
        len  = int'(r_len[id]);
        k    = r_k[id];
        stop = r_stop[id];
        run_cycles = (stop && k >= 1 && k <= len) ? k : len;
        for (int c = t + 1; c <= t + 2 + run_cycles; c++) exp_owner[c] = (id == 1);
        exp_en[t+1]   = 1'b1;
        exp_mode[t+1] = 2'b11;
        exp_D[t+1]    = r_d[id];
        for (int i = 1; i <= run_cycles; i++) begin
            exp_en[t+1+i]   = !(stop && i == k);
            exp_mode[t+1+i] = r_mode[id];
            exp_D[t+1+i]    = r_d[id];
        end
        sb.push_back('{id, t + 2 + run_cycles});
        idle_from = t + 3 + run_cycles;
        ptr_m     = (id == 0);
        rco_cycle = (k >= 0) ? t + 1 + k : -1;
    endtask

    task automatic wait_xfer(output int id);
        int n;
        n  = 0;
        id = -1;
        while (id < 0) begin
            @(negedge clk);
            #1;
            if (bus.req0_valid && bus.req0_ready) id = 0;
            else if (bus.req1_valid && bus.req1_ready) id = 1;
            else if (++n > 60) begin
                n_chk++;
                n_fail++;
                $display("FAIL xfer_timeout at cycle %0d: got no transfer, expected one", cyc);
                return;
            end
        end
        model(id, cyc);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((sb.size() != 0 || cyc < idle_from) && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 40) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain_timeout at cycle %0d: got %0d pending, expected 0", cyc, sb.size());
        end
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        exp_en.delete();
        exp_mode.delete();
        exp_D.delete();
        exp_owner.delete();
        sb.delete();
        rco_cycle = -1;
        ptr_m     = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
        idle_from = cyc;
        reset     = 1'b0;
    endtask

    initial begin
        bus.cnt_rco = 1'b0;
        bus.cnt_Q   = 4'd0;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            bus.cnt_rco = (cyc == rco_cycle);
            q_drv       = 4'($urandom);
            bus.cnt_Q   = q_drv;
        end
    end

    bit m_idle, m_e0, m_e1, m_busy, m_done;

    always @(negedge clk) begin
        if (reset) begin
            chk("reset_outputs", int'({bus.req0_ready, bus.req1_ready, bus.enable, bus.mode,
                bus.D, bus.busy, bus.owner, bus.done, bus.done_id, bus.done_q}), 0);
        end else begin
            m_idle = (cyc >= idle_from);
            m_e1   = m_idle && r_valid[1] && (!r_valid[0] || ptr_m);
            m_e0   = m_idle && r_valid[0] && !m_e1;
            chk("req0_ready", bus.req0_ready, m_e0);
            chk("req1_ready", bus.req1_ready, m_e1);
            chk("enable", bus.enable, exp_en.exists(cyc) ? int'(exp_en[cyc]) : 0);
            chk("mode", bus.mode, exp_mode.exists(cyc) ? int'(exp_mode[cyc]) : 0);
            chk("D", bus.D, exp_D.exists(cyc) ? int'(exp_D[cyc]) : 0);
            m_busy = exp_owner.exists(cyc);
            chk("busy", bus.busy, m_busy);
            if (m_busy) chk("owner", bus.owner, exp_owner[cyc]);
            m_done = (sb.size() > 0) && (sb[0].cyc == cyc);
            chk("done", bus.done, m_done);
            if (m_done) begin
                chk("done_id", bus.done_id, sb[0].id);
                chk("done_q", bus.done_q, q_drv);
                sb.delete(0);
            end
        end
    end

    initial begin
        int id;
        int order[$];
        reset = 1'b1;
        set_req(0, 1'b1, 0, 5, 3, 1'b0, -1);
        set_req(1, 1'b1, 1, 10, 2, 1'b0, -1);
        apply();
        do_reset(2);

        // Both requesters held valid: the first job is req0 d=5 len=3, then alternation.
        for (int j = 0; j < 4; j++) begin
            wait_xfer(id);
            order.push_back(id);
        end
        r_valid[0] = 1'b0;
        r_valid[1] = 1'b0;
        apply();
        for (int j = 0; j < 4; j++) chk("arb_order", order[j], j % 2);
        wait_idle();

        set_req(1, 1'b1, 2, 9, 0, 1'b0, -1);
        apply();
        wait_xfer(id);
        chk("zero_len_id", id, 1);
        r_valid[1] = 1'b0;
        apply();
        wait_idle();

        set_req(0, 1'b1, 2, 3, 15, 1'b1, 4);
        apply();
        wait_xfer(id);
        r_valid[0] = 1'b0;
        apply();
        wait_idle();
        set_req(0, 1'b1, 1, 6, 15, 1'b0, 4);
        apply();
        wait_xfer(id);
        r_valid[0] = 1'b0;
        apply();
        wait_idle();

        // Reset in the second RUN cycle of a req0 job; ptr must return to 0.
        set_req(0, 1'b1, 0, 2, 8, 1'b0, -1);
        apply();
        wait_xfer(id);
        r_valid[0] = 1'b0;
        apply();
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        do_reset(1);
        set_req(0, 1'b1, 3, 7, 0, 1'b0, -1);
        set_req(1, 1'b1, 1, 12, 2, 1'b0, -1);
        apply();
        wait_xfer(id);
        chk("ptr_after_reset", id, 0);
        r_valid[0] = 1'b0;
        apply();
        wait_xfer(id);
        chk("req1_after_reset", id, 1);
        r_valid[1] = 1'b0;
        apply();
        wait_idle();

        rand_req(0);
        rand_req(1);
        r_valid[0] = 1'b1;
        apply();
        for (int j = 0; j < 40; j++) begin
            wait_xfer(id);
            if (id < 0) break;
            rand_req(id);
            if (!r_valid[0] && !r_valid[1]) r_valid[1 - id] = 1'b1;
            apply();
        end
        r_valid[0] = 1'b0;
        r_valid[1] = 1'b0;
        apply();
        wait_idle();
        @(posedge clk);
        #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog at cycle %0d: got no end of test, expected completion", cyc);
        $fatal(1);
    end
endmodule
